// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-register view seen by the hazard unit: indices and control bits in,
// stall/flush/forward controls and bring-up counters out.
interface hazard_unit_if #(
  parameter int CNT_WIDTH = 32
);
  logic [4:0]           Rs1D, Rs2D;
  logic [4:0]           Rs1E, Rs2E, RdE;
  logic                 ResultSrcE, PCSrcE;
  logic [4:0]           RdM, RdW;
  logic                 RegWriteM, RegWriteW;
  logic                 MemReqM, MemReadyM;
  logic                 StallF, StallD, StallE, StallM;
  logic                 FlushD, FlushE, FlushW;
  logic [1:0]           ForwardAE, ForwardBE;
  logic                 MemErr;
  logic [CNT_WIDTH-1:0] StallCount, FlushCount;

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemErr, StallCount, FlushCount
  );

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemErr, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Event counter that sticks at all ones instead of wrapping.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count
);
  logic [CNT_WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (en && (count_reg != {CNT_WIDTH{1'b1}})) begin
      count_reg <= count_reg + CNT_WIDTH'(1);
    end
  end

  assign count = count_reg;
endmodule

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard control: load-use stall, branch flush, E-stage
// forwarding and a memory-wait freeze that escalates to a sticky timeout error.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst,
  hazard_unit_if.slave  hz
);
  localparam int WW = $clog2(MEM_TIMEOUT) + 1;

  state_t          state_reg, state_next;
  logic [WW-1:0]   wait_cnt_reg, wait_cnt_next;
  logic            memerr_reg, memerr_next;

  logic            lw_stall, freeze;
  logic            stall_f, stall_d, stall_e, stall_m;
  logic            flush_d, flush_e, flush_w;
  logic [1:0]      fwd [2];

  assign lw_stall = hz.ResultSrcE && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D)) && !hz.PCSrcE;
  assign freeze   = hz.MemReqM && !hz.MemReadyM;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      memerr_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      memerr_reg   <= memerr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    memerr_next   = memerr_reg;
    case (state_reg)
      RUN: begin
        if (freeze) begin
          state_next    = WAIT;
          wait_cnt_next = WW'(1);
        end
      end
      WAIT: begin
        if (!freeze) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == WW'(MEM_TIMEOUT - 1)) begin
          state_next  = ERR;
          memerr_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + WW'(1);
        end
      end
      ERR: ;
      default: state_next = RUN;
    endcase
  end

  // The freeze holds D/E in place, so a pending branch or load-use simply
  // re-presents itself in the first unfrozen cycle.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if ((state_reg == ERR) || freeze) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      stall_f = lw_stall;
      stall_d = lw_stall;
      flush_d = hz.PCSrcE;
      flush_e = lw_stall || hz.PCSrcE;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic [4:0] src;
      assign src = (gi == 0) ? hz.Rs1E : hz.Rs2E;
      always_comb begin
        fwd[gi] = FWD_RF;
        if (!rst) begin
          if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == src)) begin
            fwd[gi] = FWD_M;
          end else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == src)) begin
            fwd[gi] = FWD_W;
          end
        end
      end
    end
  endgenerate

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .srst  (rst),
    .en    (stall_f || stall_d || stall_e || stall_m),
    .count (hz.StallCount)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .srst  (rst),
    .en    ((flush_d || flush_e) && !rst),
    .count (hz.FlushCount)
  );

  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.FlushW    = flush_w;
  assign hz.ForwardAE = fwd[0];
  assign hz.ForwardBE = fwd[1];
  assign hz.MemErr    = memerr_reg;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed plus randomized check of hazard_unit against an in-bench model;
// a 4-bit-counter copy runs on the same stimulus to exercise saturation.
module tb_hazard_unit;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  hazard_unit_if #(.CNT_WIDTH(32)) a ();
  hazard_unit_if #(.CNT_WIDTH(4))  b ();

  hazard_unit #(.CNT_WIDTH(32), .MEM_TIMEOUT(TMO)) dut32 (.clk(clk), .rst(rst), .hz(a));
  hazard_unit #(.CNT_WIDTH(4),  .MEM_TIMEOUT(TMO)) dut4  (.clk(clk), .rst(rst), .hz(b));

  assign b.Rs1D = a.Rs1D;             assign b.Rs2D = a.Rs2D;
  assign b.Rs1E = a.Rs1E;             assign b.Rs2E = a.Rs2E;
  assign b.RdE = a.RdE;               assign b.ResultSrcE = a.ResultSrcE;
  assign b.PCSrcE = a.PCSrcE;         assign b.RdM = a.RdM;
  assign b.RdW = a.RdW;               assign b.RegWriteM = a.RegWriteM;
  assign b.RegWriteW = a.RegWriteW;   assign b.MemReqM = a.MemReqM;
  assign b.MemReadyM = a.MemReadyM;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a.Rs1D = 0; a.Rs2D = 0; a.Rs1E = 0; a.Rs2E = 0; a.RdE = 0;
    a.ResultSrcE = 0; a.PCSrcE = 0; a.RdM = 0; a.RdW = 0;
    a.RegWriteM = 0; a.RegWriteW = 0; a.MemReqM = 0; a.MemReadyM = 1;
  endtask

  function automatic logic [1:0] fwd_model(input logic [4:0] src);
    if (a.RegWriteM && a.RdM != 0 && a.RdM == src) return 2'b10;
    if (a.RegWriteW && a.RdW != 0 && a.RdW == src) return 2'b01;
    return 2'b00;
  endfunction

  // Model state: error flag, length of the current freeze run, raw event totals.
  bit     m_err = 0;
  int     m_frz = 0;
  longint c_st = 0, c_fl = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      bit lw, frz, hold;
      bit e_sf, e_sd, e_fd, e_fe, e_fw, e_sem;
      logic [1:0] e_fa, e_fb;
      lw   = a.ResultSrcE && a.RdE != 0 && (a.RdE == a.Rs1D || a.RdE == a.Rs2D) && !a.PCSrcE;
      frz  = a.MemReqM && !a.MemReadyM;
      hold = !rst && (m_err || frz);
      e_sem = hold;
      e_sf = hold || (!rst && lw);
      e_sd = e_sf;
      e_fw = rst || hold;
      e_fd = rst || (!hold && a.PCSrcE);
      e_fe = rst || (!hold && (a.PCSrcE || lw));
      e_fa = rst ? 2'b00 : fwd_model(a.Rs1E);
      e_fb = rst ? 2'b00 : fwd_model(a.Rs2E);
      chk("StallF", a.StallF, e_sf);
      chk("StallD", a.StallD, e_sd);
      chk("StallE", a.StallE, e_sem);
      chk("StallM", a.StallM, e_sem);
      chk("FlushD", a.FlushD, e_fd);
      chk("FlushE", a.FlushE, e_fe);
      chk("FlushW", a.FlushW, e_fw);
      chk("ForwardAE", a.ForwardAE, e_fa);
      chk("ForwardBE", a.ForwardBE, e_fb);
      chk("MemErr", a.MemErr, m_err);
      chk("StallCount", a.StallCount, c_st);
      chk("FlushCount", a.FlushCount, c_fl);
      chk("StallCount4", b.StallCount, (c_st > 15) ? 15 : c_st);
      chk("FlushCount4", b.FlushCount, (c_fl > 15) ? 15 : c_fl);
      chk("MemErr4", b.MemErr, m_err);
      if (rst) begin
        m_err = 0; m_frz = 0; c_st = 0; c_fl = 0;
      end else begin
        if (e_sf || e_sem) c_st++;
        if (e_fd || e_fe) c_fl++;
        if (!m_err) begin
          if (frz) begin
            m_frz++;
            if (m_frz >= TMO) m_err = 1;
          end else begin
            m_frz = 0;
          end
        end
      end
    end
  end

  initial begin
    clear_inputs();
    rst = 1;
    tick();
    chk_en = 1;
    // Reset forces bubbles and suppresses forwarding even on a match.
    a.RegWriteM = 1; a.RdM = 5; a.Rs1E = 5;
    tick();
    #1;
    chk("rst FlushD", a.FlushD, 1);
    chk("rst FlushE", a.FlushE, 1);
    chk("rst FlushW", a.FlushW, 1);
    chk("rst StallF", a.StallF, 0);
    chk("rst ForwardAE", a.ForwardAE, 0);
    rst = 0;
    clear_inputs();
    #1;
    chk("reset MemErr", a.MemErr, 0);
    chk("reset StallCount", a.StallCount, 0);
    chk("reset FlushCount", a.FlushCount, 0);

    // Forward priority M over W, then W only, then x0 never forwards.
    a.RegWriteM = 1; a.RdM = 5; a.RegWriteW = 1; a.RdW = 5; a.Rs1E = 5; a.Rs2E = 5;
    #1;
    chk("fwd M prio A", a.ForwardAE, 2);
    chk("fwd M prio B", a.ForwardBE, 2);
    tick();
    a.RegWriteM = 0;
    #1;
    chk("fwd W A", a.ForwardAE, 1);
    tick();
    a.RegWriteM = 1; a.RdM = 0; a.RdW = 0; a.Rs1E = 0;
    #1;
    chk("fwd x0 A", a.ForwardAE, 0);
    tick();

    // Load-use stall.
    clear_inputs();
    a.ResultSrcE = 1; a.RdE = 7; a.Rs2D = 7;
    #1;
    chk("lu StallF", a.StallF, 1);
    chk("lu StallD", a.StallD, 1);
    chk("lu FlushE", a.FlushE, 1);
    chk("lu FlushD", a.FlushD, 0);
    tick();
    chk("lu StallCount", a.StallCount, 1);
    chk("lu FlushCount", a.FlushCount, 1);

    // Branch overrides the load-use stall.
    a.PCSrcE = 1;
    #1;
    chk("br FlushD", a.FlushD, 1);
    chk("br FlushE", a.FlushE, 1);
    chk("br StallF", a.StallF, 0);
    tick();
    chk("br FlushCount", a.FlushCount, 2);
    chk("br StallCount", a.StallCount, 1);

    // Three-cycle memory wait.
    clear_inputs();
    a.MemReqM = 1; a.MemReadyM = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("mw StallM", a.StallM, 1);
      chk("mw FlushW", a.FlushW, 1);
      tick();
    end
    a.MemReadyM = 1;
    #1;
    chk("mw done StallF", a.StallF, 0);
    chk("mw done FlushW", a.FlushW, 0);
    tick();
    chk("mw MemErr", a.MemErr, 0);
    chk("mw StallCount", a.StallCount, 4);

    // Timeout after exactly TMO frozen edges.
    a.MemReadyM = 0;
    for (int k = 0; k < TMO; k++) begin
      chk("tmo pre MemErr", a.MemErr, 0);
      tick();
    end
    chk("tmo MemErr", a.MemErr, 1);
    a.MemReadyM = 1;
    #1;
    chk("err StallF", a.StallF, 1);
    chk("err FlushD", a.FlushD, 0);
    tick();
    chk("err sticky", a.MemErr, 1);
    rst = 1;
    #1;
    chk("err rst FlushD", a.FlushD, 1);
    chk("err rst FlushE", a.FlushE, 1);
    tick();
    rst = 0;
    clear_inputs();
    chk("post rst MemErr", a.MemErr, 0);
    chk("post rst StallCount", a.StallCount, 0);
    chk("post rst FlushCount4", b.FlushCount, 0);

    // Saturation of the 4-bit copy.
    a.ResultSrcE = 1; a.RdE = 3; a.Rs1D = 3;
    for (int k = 0; k < 20; k++) tick();
    chk("sat StallCount4", b.StallCount, 15);
    chk("sat StallCount32", a.StallCount, 20);

    // Randomized phase with periodic long freezes and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      a.Rs1D = 5'($urandom_range(0, 3)); a.Rs2D = 5'($urandom_range(0, 3));
      a.Rs1E = 5'($urandom_range(0, 3)); a.Rs2E = 5'($urandom_range(0, 3));
      a.RdE  = 5'($urandom_range(0, 3)); a.RdM  = 5'($urandom_range(0, 3));
      a.RdW  = 5'($urandom_range(0, 3));
      a.ResultSrcE = 1'($urandom_range(0, 1));
      a.PCSrcE     = ($urandom_range(0, 3) == 0);
      a.RegWriteM  = 1'($urandom_range(0, 1));
      a.RegWriteW  = 1'($urandom_range(0, 1));
      if ((i % 400) >= 370) begin
        a.MemReqM = 1; a.MemReadyM = 0;
      end else begin
        a.MemReqM   = 1'($urandom_range(0, 1));
        a.MemReadyM = ($urandom_range(0, 2) != 0);
      end
      tick();
    end
    rst = 0;
    clear_inputs();
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
